// File: rtl/game_update_ctrl.sv
// game_update_ctrl: once-per-frame sequencer that moves the player, advances/fires the bullet and publishes atomically.
module game_update_ctrl #(
  parameter int CORDW         = 10,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int PLAYER_W      = 16,
  parameter int PLAYER_Y      = 400,
  parameter int PLAYER_X_INIT = 312,
  parameter int PLAYER_STEP   = 2,
  parameter int BULLET_STEP   = 4,
  parameter int BULLET_H      = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [CORDW-1:0] sx_i,
  input  logic [CORDW-1:0] sy_i,
  input  logic             left_i,
  input  logic             right_i,
  input  logic             shoot_i,
  output logic [CORDW-1:0] player_x_o,
  output logic [CORDW-1:0] bullet_x_o,
  output logic [CORDW-1:0] bullet_y_o,
  output logic             bullet_active_o,
  output logic [7:0]       shots_o,
  output logic             busy_o,
  output logic             frame_o
);
  typedef enum logic [2:0] {IDLE, SAMPLE, PLAYER, BULLET, FIRE, PUBLISH} state_t;
  localparam logic [CORDW:0]   P_STEP = (CORDW+1)'(PLAYER_STEP);
  localparam logic [CORDW:0]   X_MAX  = (CORDW+1)'(H_RES - PLAYER_W);
  localparam logic [CORDW-1:0] B_STEP = CORDW'(BULLET_STEP);
  state_t           state;
  logic             l_q, r_q, fire_req, prev_shoot, wb_act;
  logic [CORDW-1:0] wp_x, wb_x, wb_y;
  logic [7:0]       shots;
  logic [CORDW:0]   px_w, left_x, right_x;
  // one extra bit so the clamp comparisons cannot wrap
  assign px_w    = {1'b0, wp_x};
  assign left_x  = (px_w >= P_STEP) ? px_w - P_STEP : '0;
  assign right_x = (px_w + P_STEP <= X_MAX) ? px_w + P_STEP : X_MAX;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= IDLE;
      l_q             <= 1'b0;
      r_q             <= 1'b0;
      fire_req        <= 1'b0;
      prev_shoot      <= 1'b1;
      wp_x            <= CORDW'(PLAYER_X_INIT);
      wb_x            <= '0;
      wb_y            <= '0;
      wb_act          <= 1'b0;
      shots           <= '0;
      player_x_o      <= CORDW'(PLAYER_X_INIT);
      bullet_x_o      <= '0;
      bullet_y_o      <= '0;
      bullet_active_o <= 1'b0;
      shots_o         <= '0;
      busy_o          <= 1'b0;
      frame_o         <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      case (state)
        IDLE: if (sx_i == '0 && sy_i == CORDW'(V_RES)) begin
          state  <= SAMPLE;
          busy_o <= 1'b1;
        end
        SAMPLE: begin
          l_q        <= left_i;
          r_q        <= right_i;
          fire_req   <= shoot_i && !prev_shoot;
          prev_shoot <= shoot_i;
          state      <= PLAYER;
        end
        PLAYER: begin
          if (l_q && !r_q) wp_x <= left_x[CORDW-1:0];
          else if (r_q && !l_q) wp_x <= right_x[CORDW-1:0];
          state <= BULLET;
        end
        BULLET: begin
          if (wb_act) begin
            if (wb_y < B_STEP) wb_act <= 1'b0;
            else wb_y <= wb_y - B_STEP;
          end
          state <= FIRE;
        end
        // runs after BULLET so a retiring bullet can be replaced in the same frame
        FIRE: begin
          if (fire_req && !wb_act) begin
            wb_act <= 1'b1;
            wb_x   <= wp_x + CORDW'(PLAYER_W/2 - 1);
            wb_y   <= CORDW'(PLAYER_Y - BULLET_H);
            shots  <= shots + 8'd1;
          end
          state <= PUBLISH;
        end
        PUBLISH: begin
          player_x_o      <= wp_x;
          bullet_x_o      <= wb_x;
          bullet_y_o      <= wb_y;
          bullet_active_o <= wb_act;
          shots_o         <= shots;
          frame_o         <= 1'b1;
          busy_o          <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/game_update_ctrl.md
# game_update_ctrl

Per-frame game-state sequencer for the space-invaders pipeline. Sits between the synchronized button inputs and the pixel-drawing logic, and runs on the 25 MHz pixel clock next to `dvi_controller`. Once per frame, at the start of vertical blanking, it steps a small state machine through four updates: player movement, bullet advance, firing, and an atomic publish of the new positions. Drawing logic therefore never sees a half-updated frame.

## Interface
Parameters:
- CORDW, 10: coordinate width; matches `sx`/`sy` of `dvi_controller`.
- H_RES, 640: active horizontal pixels.
- V_RES, 480: active lines; the update trigger fires at `sy_i == V_RES`.
- PLAYER_W, 16: player sprite width in pixels.
- PLAYER_Y, 400: fixed top row of the player.
- PLAYER_X_INIT, 312: player x after reset.
- PLAYER_STEP, 2: pixels moved per frame.
- BULLET_STEP, 4: pixels the bullet rises per frame.
- BULLET_H, 8: bullet height in pixels.

Ports:
- clk_i, input, 1: pixel clock. One clock domain only.
- reset_i, input, 1: synchronous reset, active-high.
- sx_i, input, CORDW: current pixel x from `dvi_controller`.
- sy_i, input, CORDW: current pixel y from `dvi_controller`.
- left_i, input, 1: move-left level, already synchronized.
- right_i, input, 1: move-right level, already synchronized.
- shoot_i, input, 1: fire level, already synchronized (`sync_button` output).
- player_x_o, output, CORDW: published player left x.
- bullet_x_o, output, CORDW: published bullet left x.
- bullet_y_o, output, CORDW: published bullet top y.
- bullet_active_o, output, 1: published bullet-visible flag.
- shots_o, output, 8: count of bullets fired; wraps modulo 256.
- busy_o, output, 1: high while the state machine is not IDLE.
- frame_o, output, 1: one-cycle pulse when new values are published.

## Operation
- Trigger: `sx_i == 0 && sy_i == V_RES`, sampled only in IDLE. A trigger seen in any other state is ignored.
- Working registers (wp_x, wb_x, wb_y, wb_act, shot count) are separate from the published output registers. Outputs change only on the PUBLISH edge.
- States run in fixed order, one cycle each: IDLE -> SAMPLE -> PLAYER -> BULLET -> FIRE -> PUBLISH -> IDLE.
- SAMPLE:
  - Latch left_i, right_i and shoot_i.
  - fire_req = shoot latched && !prev_shoot.
  - prev_shoot <= shoot latched. This gives one shot per press, evaluated per frame.
- PLAYER:
  - Left only: wp_x <= (wp_x >= PLAYER_STEP) ? wp_x - PLAYER_STEP : 0.
  - Right only: wp_x <= (wp_x + PLAYER_STEP <= H_RES - PLAYER_W) ? wp_x + PLAYER_STEP : H_RES - PLAYER_W.
  - Both or neither: no change.
  - Compare in CORDW+1 bits so nothing wraps.
- BULLET:
  - If wb_act: when wb_y < BULLET_STEP, clear wb_act and leave wb_y unchanged; otherwise wb_y <= wb_y - BULLET_STEP.
  - wb_x never changes here.
- FIRE:
  - If fire_req && !wb_act:
    - wb_act <= 1.
    - wb_x <= wp_x + PLAYER_W/2 - 1, using the post-move player x.
    - wb_y <= PLAYER_Y - BULLET_H.
    - Shot count += 1.
  - A fire request is dropped, not queued, when a bullet is already active.
  - Because BULLET runs before FIRE, a bullet that retires this frame can be replaced in the same frame. A newly fired bullet is not advanced until the next frame.
- PUBLISH: copy all working registers to the outputs and assert frame_o.
- Reset (any state, including mid-sequence) returns to IDLE and sets:
  - player_x_o = wp_x = PLAYER_X_INIT.
  - bullet_x_o = bullet_y_o = 0, bullet_active_o = 0.
  - shots_o = 0, busy_o = 0, frame_o = 0.
  - prev_shoot = 1, so a button held through reset does not fire.

## Timing
- Edge E0 sees the trigger in IDLE. State is then SAMPLE after E0, PLAYER after E1, BULLET after E2, FIRE after E3, PUBLISH after E4, IDLE after E5.
- Outputs take their new values at E5, and frame_o is high for exactly the cycle following E5.
- Latency from trigger to published outputs: 5 clocks.
- busy_o is high for exactly 5 cycles, from E0 to E5.
- Inputs are sampled only at E1. Button changes at any other time have no effect on that frame.
- Exactly one update per frame. The trigger recurs every 800×525 clocks.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Reset hold:** hold shoot_i=1 through reset, then run 3 frames. Required: player_x_o=312 throughout, bullet_active_o=0, shots_o=0, frame_o pulses 3 times with busy_o high for 5 cycles each.
- **Left clamp:** hold left_i for 200 frames. Required: player_x_o falls 312, 310, … and saturates at 0. Then right_i for 400 frames saturates at 624. With both held, x does not change.
- **Fire and climb:** at player_x=312, pulse shoot_i for one frame.
  - Required at the next publish: bullet_x_o=319, bullet_y_o=392, active=1, shots_o=1.
  - Each subsequent frame y drops by 4.
  - When y reaches 0 the next frame clears active, with y held at 0.
- **Held button and busy fire:** keep shoot_i high for 10 frames. Required: exactly one shot. A second press while the bullet is active leaves shots_o unchanged.
- **Same-frame replace:** bullet at y=2 and a new press in the same frame. Required: that publish shows active=1, y=392, shots incremented. Also check shots_o wraps 255 -> 0.
- **Mid-sequence reset:** assert reset_i in the PLAYER state. Required: IDLE next cycle, all outputs at reset values, no frame_o pulse. The next trigger runs a normal 5-cycle sequence.
